// File: rtl/bc_microseq_pkg.sv
// Shared types and helpers for the bc_microseq control block.
package bc_microseq_pkg;

  // Sequencer states; outputs are decoded from these.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Control word width: {last, h, ld, sel}.
  function automatic int unsigned cw_width(int unsigned n_mux, int unsigned sel_w,
                                           int unsigned n_load);
    return n_mux * sel_w + n_load + 2;
  endfunction

endpackage

// File: rtl/bc_microseq_ucode_ram.sv
// Control-word table: one synchronous write port, one combinational read port,
// cleared to all-zero on reset.
module bc_microseq_ucode_ram #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 11,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];

  logic waddr_ok;
  logic raddr_ok;

  // Addresses beyond Depth exist only when Depth is not a power of two.
  assign waddr_ok = ({1'b0, waddr} < (AddrW + 1)'(Depth));
  assign raddr_ok = ({1'b0, raddr} < (AddrW + 1)'(Depth));

  // Next table contents: apply the write when enabled and in range.
  always_comb begin
    mem_d = mem_q;
    if (we && waddr_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  // Table storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read port.
  always_comb begin
    rdata = '0;
    if (raddr_ok) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/bc_microseq.sv
// Programmable microsequencer: walks a writable control-word table, driving the
// datapath mux selects, load enables and op flag, with multi-pass runs and abort.
module bc_microseq
  import bc_microseq_pkg::*;
#(
  parameter int unsigned N_STEPS   = 8,
  parameter int unsigned N_MUX     = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned N_LOAD    = 3,
  parameter int unsigned ITER_W    = 4,
  parameter bit          DONE_HOLD = 1'b0,
  localparam int unsigned SP_W     = $clog2(N_STEPS),
  localparam int unsigned CW_W     = cw_width(N_MUX, SEL_W, N_LOAD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     permit,
  input  logic [ITER_W-1:0]        iter,
  input  logic                     abort,
  input  logic                     ack,
  input  logic                     prog_we,
  input  logic [SP_W-1:0]          prog_addr,
  input  logic [CW_W-1:0]          prog_data,
  output logic [N_MUX*SEL_W-1:0]   sel,
  output logic [N_LOAD-1:0]        ld,
  output logic                     h,
  output logic                     ready,
  output logic                     feito,
  output logic                     busy,
  output logic                     prog_err
);

  localparam int unsigned SelBits = N_MUX * SEL_W;
  localparam int unsigned LdLsb   = SelBits;
  localparam int unsigned HBit    = SelBits + N_LOAD;
  localparam int unsigned LastBit = HBit + 1;

  state_e            state_q, state_d;
  logic [SP_W-1:0]   step_q, step_d;
  logic [ITER_W-1:0] loop_q, loop_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              prog_err_q, prog_err_d;

  logic [CW_W-1:0]   cw;
  logic              tbl_we;
  logic              pass_end;
  logic              more_passes;

  // Writes only land while idle; elsewhere they are dropped and flagged.
  assign tbl_we = prog_we && (state_q == StIdle);

  bc_microseq_ucode_ram #(
    .Depth (N_STEPS),
    .Width (CW_W),
    .AddrW (SP_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (step_q),
    .rdata (cw)
  );

  assign pass_end    = (step_q == SP_W'(N_STEPS - 1)) || cw[LastBit];
  // iter_q is never 0 in RUN, so the subtraction cannot underflow.
  assign more_passes = (loop_q < (iter_q - ITER_W'(1)));

  // Next-state logic for the FSM, counters and error flag.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    loop_d     = loop_q;
    iter_d     = iter_q;
    prog_err_d = prog_we && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (permit) begin
          state_d = StRun;
          step_d  = '0;
          loop_d  = '0;
          iter_d  = (iter == '0) ? ITER_W'(1) : iter;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          step_d  = '0;
          loop_d  = '0;
        end else if (pass_end) begin
          step_d = '0;
          if (more_passes) begin
            loop_d = loop_q + ITER_W'(1);
          end else begin
            loop_d  = '0;
            state_d = StDone;
          end
        end else begin
          step_d = step_q + SP_W'(1);
        end
      end
      StDone: begin
        if (!DONE_HOLD || ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
        loop_d  = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      step_q     <= '0;
      loop_q     <= '0;
      iter_q     <= '0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      loop_q     <= loop_d;
      iter_q     <= iter_d;
      prog_err_q <= prog_err_d;
    end
  end

  // Moore output decode; the table is frozen outside IDLE so these are stable.
  always_comb begin
    sel      = '0;
    ld       = '0;
    h        = 1'b0;
    ready    = (state_q == StIdle);
    busy     = (state_q == StRun);
    feito    = (state_q == StDone);
    prog_err = prog_err_q;
    if (state_q == StRun) begin
      sel = cw[SelBits-1:0];
      ld  = cw[LdLsb +: N_LOAD];
      h   = cw[HBit];
    end
  end

endmodule

// File: tb/tb_bc_microseq.sv
// Self-checking bench for bc_microseq: table-driven runs checked through a
// scoreboard queue, plus hand-written reset, abort, hold and write-drop cases.
module tb_bc_microseq;

  localparam int NS = 8;
  localparam int CW = 11;

  // Observed vector layout: {sel[5:0], ld[2:0], h, ready, busy, feito, prog_err}
  localparam logic [13:0] EXP_IDLE = 14'h0008;
  localparam logic [13:0] EXP_DONE = 14'h0002;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          permit_a = 1'b0, abort_a = 1'b0, we_a = 1'b0;
  logic [3:0]    iter_a = '0;
  logic [2:0]    addr_a = '0;
  logic [CW-1:0] data_a = '0;
  logic [5:0]    sel_a;
  logic [2:0]    ld_a;
  logic          h_a, ready_a, feito_a, busy_a, err_a;

  logic          permit_b = 1'b0, ack_b = 1'b0, we_b = 1'b0;
  logic [2:0]    addr_b = '0;
  logic [CW-1:0] data_b = '0;
  logic [5:0]    sel_b;
  logic [2:0]    ld_b;
  logic          h_b, ready_b, feito_b, busy_b, err_b;

  logic [13:0] obs_a, obs_b;
  assign obs_a = {sel_a, ld_a, h_a, ready_a, busy_a, feito_a, err_a};
  assign obs_b = {sel_b, ld_b, h_b, ready_b, busy_b, feito_b, err_b};

  always #5 clk = ~clk;

  bc_microseq #(.DONE_HOLD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .permit(permit_a), .iter(iter_a), .abort(abort_a),
    .ack(1'b0), .prog_we(we_a), .prog_addr(addr_a), .prog_data(data_a),
    .sel(sel_a), .ld(ld_a), .h(h_a), .ready(ready_a), .feito(feito_a),
    .busy(busy_a), .prog_err(err_a)
  );

  bc_microseq #(.DONE_HOLD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .permit(permit_b), .iter(4'd1), .abort(1'b0),
    .ack(ack_b), .prog_we(we_b), .prog_addr(addr_b), .prog_data(data_b),
    .sel(sel_b), .ld(ld_b), .h(h_b), .ready(ready_b), .feito(feito_b),
    .busy(busy_b), .prog_err(err_b)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [CW-1:0] shadow [NS];

  typedef struct {
    int iter;
    int last_at;   // -1: no last bit anywhere
    int exp_run;   // RUN cycles expected
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] run_word(input logic [CW-1:0] w);
    return {w[5:0], w[8:6], w[9], 4'b0100};
  endfunction

  task automatic prog_a(input int addr, input logic [CW-1:0] w);
    @(negedge clk);
    we_a = 1'b1; addr_a = 3'(addr); data_a = w;
    @(posedge clk);
    #1 we_a = 1'b0;
    shadow[addr] = w;
  endtask

  task automatic load_program(input int last_at);
    logic [CW-1:0] w;
    for (int s = 0; s < NS; s++) begin
      w = CW'($urandom);
      w[10] = (s == last_at);
      prog_a(s, w);
    end
  endtask

  // Start a run on dut_a and check every cycle through to the return to IDLE.
  // wr_at >= 0 issues a (dropped) table write at that observed cycle.
  // same_wr writes a fresh step-0 word in the permit cycle.
  task automatic run_a(input int iter, input int exp_run, input int wr_at, input bit same_wr);
    logic [13:0] q[$];
    logic [13:0] e;
    logic [CW-1:0] w;
    int passes, len, busy_cnt, idx;
    @(negedge clk);
    permit_a = 1'b1;
    iter_a   = 4'(iter);
    if (same_wr) begin
      w = CW'($urandom);
      w[10] = 1'b0;
      we_a = 1'b1; addr_a = 3'd0; data_a = w;
      shadow[0] = w;
    end
    passes = (iter == 0) ? 1 : iter;
    len = NS;
    for (int s = NS - 1; s >= 0; s--) if (shadow[s][10]) len = s + 1;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < len; s++) q.push_back(run_word(shadow[s]));
    q.push_back(EXP_DONE);
    q.push_back(EXP_IDLE);
    if (wr_at >= 0) q[wr_at + 1][0] = 1'b1;
    @(posedge clk);
    #1 permit_a = 1'b0; we_a = 1'b0;
    busy_cnt = 0;
    idx = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check("run_seq", 32'(obs_a), 32'(e));
      if (busy_a) busy_cnt++;
      if (idx == wr_at) begin
        we_a = 1'b1; addr_a = 3'd0; data_a = ~shadow[0];
      end else begin
        we_a = 1'b0;
      end
      idx++;
    end
    we_a = 1'b0;
    check("run_len", 32'(busy_cnt), 32'(exp_run));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] w0, w1;
    vecs[0] = '{iter: 1,  last_at: 3,  exp_run: 4};
    vecs[1] = '{iter: 3,  last_at: 3,  exp_run: 12};
    vecs[2] = '{iter: 0,  last_at: 3,  exp_run: 4};
    vecs[3] = '{iter: 1,  last_at: -1, exp_run: 8};
    vecs[4] = '{iter: 2,  last_at: 1,  exp_run: 4};
    vecs[5] = '{iter: 15, last_at: 0,  exp_run: 15};
    for (int s = 0; s < NS; s++) shadow[s] = '0;

    #12;
    check("reset_a", 32'(obs_a), 32'(EXP_IDLE));
    check("reset_b", 32'(obs_b), 32'(EXP_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Table-driven runs.
    for (int v = 0; v < 6; v++) begin
      load_program(vecs[v].last_at);
      run_a(vecs[v].iter, vecs[v].exp_run, -1, 1'b0);
    end

    // Write and permit in the same IDLE cycle: step 0 uses the new word.
    load_program(3);
    run_a(1, 4, -1, 1'b1);

    // Write during RUN is dropped and flagged; the next run sees the old table.
    run_a(2, 8, 5, 1'b0);
    run_a(1, 4, -1, 1'b0);

    // Abort at step 2 where last is also set.
    load_program(2);
    @(negedge clk);
    permit_a = 1'b1; iter_a = 4'd1;
    @(posedge clk);
    #1 permit_a = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("abort_run", 32'(obs_a), 32'(run_word(shadow[s])));
    end
    abort_a = 1'b1;
    @(posedge clk);
    #1 abort_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_idle", 32'(obs_a), 32'(EXP_IDLE));
    end

    // Reset mid-RUN at step 3, then the cleared table runs as all-zero words.
    load_program(-1);
    @(negedge clk);
    permit_a = 1'b1; iter_a = 4'd1;
    @(posedge clk);
    #1 permit_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("pre_reset_run", 32'(obs_a), 32'(run_word(shadow[s])));
    end
    #2 rst = 1'b0;
    #1 check("async_reset", 32'(obs_a), 32'(EXP_IDLE));
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < NS; s++) shadow[s] = '0;
    run_a(1, 8, -1, 1'b0);

    // DONE_HOLD instance: feito held until ack, permit ignored meanwhile.
    w0 = CW'($urandom); w0[10] = 1'b0;
    w1 = CW'($urandom); w1[10] = 1'b1;
    @(negedge clk);
    we_b = 1'b1; addr_b = 3'd0; data_b = w0;
    @(negedge clk);
    addr_b = 3'd1; data_b = w1;
    @(negedge clk);
    we_b = 1'b0; permit_b = 1'b1;
    @(posedge clk);
    #1 permit_b = 1'b0;
    @(negedge clk);
    check("hold_run0", 32'(obs_b), 32'(run_word(w0)));
    @(negedge clk);
    check("hold_run1", 32'(obs_b), 32'(run_word(w1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done", 32'(obs_b), 32'(EXP_DONE));
      if (i < 4) permit_b = 1'b1;
      else begin
        permit_b = 1'b0;
        ack_b = 1'b1;
      end
    end
    @(posedge clk);
    #1 ack_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_idle", 32'(obs_b), 32'(EXP_IDLE));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
